// File: rtl/drum_motor_driver.sv
// rtl/drum_motor_driver.sv - ramped PWM drum motor driver with brake phase and latched fault supervision
// Optional build macro DRUM_DIR_ALT_EN adds alternating-direction tumbling at low speed commands.
module drum_motor_driver #(
  parameter int unsigned RAMP_DIV       = 1000,
  parameter int unsigned RAMP_STEP      = 4,
  parameter int unsigned BRAKE_CLKS     = 2000,
  parameter logic [7:0]  STALL_DUTY     = 8'd64,
  parameter logic [9:0]  STALL_SPEED    = 10'd20,
  parameter int unsigned STALL_LIMIT    = 3000,
  parameter int unsigned VIB_LIMIT      = 500,
  parameter int unsigned DIR_PERIOD     = 50,
  parameter logic [3:0]  TUMBLE_MAX_CMD = 4'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] drum_motor,
  input  logic [9:0] motor_speed_sensor,
  input  logic       vibration_sensor,
  input  logic       door_locked,
  input  logic       fault_clear,
  output logic       pwm_out,
  output logic       motor_enable,
  output logic       brake,
  output logic       motor_dir,
  output logic       at_speed,
  output logic       motor_fault,
  output logic [1:0] fault_code
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_BRAKE     = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam logic [15:0] PRESC_LAST = 16'(RAMP_DIV - 1);
  localparam logic [15:0] BRAKE_LAST = 16'(BRAKE_CLKS - 1);
  localparam logic [15:0] STALL_LAST = 16'(STALL_LIMIT - 1);
  localparam logic [15:0] VIB_LAST   = 16'(VIB_LIMIT - 1);
  localparam logic [8:0]  STEP9      = 9'(RAMP_STEP);

  state_e      state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] brake_cnt_q, brake_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] vib_cnt_q, vib_cnt_d;
  logic [1:0]  code_q, code_d;

  logic        tick;
  logic        stall_cond;
  logic        rev_q;
  logic        tumble_start;
  logic [7:0]  cmd_target;
  logic [7:0]  target_eff;
  logic [8:0]  up_sum;
  logic [8:0]  down_floor;
  logic [7:0]  up_val;
  logic [7:0]  down_val;

  assign tick       = (presc_q == PRESC_LAST);
  assign cmd_target = {drum_motor, drum_motor};
  // A reversal in progress drives the ramp towards zero regardless of the command.
  assign target_eff = rev_q ? 8'd0 : cmd_target;
  assign stall_cond = (duty_q >= STALL_DUTY) && (motor_speed_sensor < STALL_SPEED);

  // Saturating ramp steps computed with a 9-bit intermediate so they never wrap.
  assign up_sum     = {1'b0, duty_q} + STEP9;
  assign up_val     = (up_sum > {1'b0, target_eff}) ? target_eff : up_sum[7:0];
  assign down_floor = {1'b0, target_eff} + STEP9;
  assign down_val   = ({1'b0, duty_q} < down_floor) ? target_eff : (duty_q - STEP9[7:0]);

  // State register plus datapath flops; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      duty_q      <= 8'd0;
      presc_q     <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      brake_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
      vib_cnt_q   <= 16'd0;
      code_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      brake_cnt_q <= brake_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      vib_cnt_q   <= vib_cnt_d;
      code_q      <= code_d;
    end
  end

  // Next-state: supervision has priority over ramp control while the stage is driven.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    code_d      = code_q;
    presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    brake_cnt_d = 16'd0;
    stall_cnt_d = 16'd0;
    vib_cnt_d   = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (drum_motor != 4'd0) state_d = S_RAMP_UP;
      end
      S_RAMP_UP, S_RUN, S_RAMP_DOWN: begin
        stall_cnt_d = stall_cond ? stall_cnt_q + 16'd1 : 16'd0;
        vib_cnt_d   = vibration_sensor ? vib_cnt_q + 16'd1 : 16'd0;
        if (!door_locked) begin
          state_d = S_FAULT;
          code_d  = 2'b11;
        end else if (stall_cond && (stall_cnt_q == STALL_LAST)) begin
          state_d = S_FAULT;
          code_d  = 2'b01;
        end else if (vibration_sensor && (vib_cnt_q == VIB_LAST)) begin
          state_d = S_FAULT;
          code_d  = 2'b10;
        end else if (state_q == S_RAMP_UP) begin
          if ((target_eff < duty_q) || (target_eff == 8'd0)) state_d = S_RAMP_DOWN;
          else if (duty_q == target_eff)                        state_d = S_RUN;
          else if (tick)                                        duty_d  = up_val;
        end else if (state_q == S_RUN) begin
          if (tumble_start)                                          state_d = S_RAMP_DOWN;
          else if (target_eff > duty_q)                              state_d = S_RAMP_UP;
          else if ((target_eff < duty_q) || (target_eff == 8'd0))    state_d = S_RAMP_DOWN;
        end else begin
          if (target_eff > duty_q) state_d = S_RAMP_UP;
          else if (duty_q == target_eff) state_d = (target_eff == 8'd0) ? S_BRAKE : S_RUN;
          else if (tick) duty_d = down_val;
        end
        if (state_d == S_FAULT) begin
          duty_d      = 8'd0;
          stall_cnt_d = 16'd0;
          vib_cnt_d   = 16'd0;
        end
      end
      S_BRAKE: begin
        brake_cnt_d = brake_cnt_q + 16'd1;
        if (brake_cnt_q == BRAKE_LAST) begin
          brake_cnt_d = 16'd0;
          state_d     = (rev_q && (drum_motor != 4'd0)) ? S_RAMP_UP : S_IDLE;
        end
      end
      S_FAULT: begin
        duty_d = 8'd0;
        if (fault_clear && (drum_motor == 4'd0)) begin
          state_d = S_IDLE;
          code_d  = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        duty_d  = 8'd0;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    motor_enable = 1'b0;
    brake        = 1'b0;
    motor_fault  = 1'b0;
    at_speed     = 1'b0;
    case (state_q)
      S_RAMP_UP, S_RAMP_DOWN: motor_enable = 1'b1;
      S_RUN: begin
        motor_enable = 1'b1;
        at_speed     = (duty_q == target_eff) && !rev_q;
      end
      S_BRAKE: brake = 1'b1;
      S_FAULT: begin
        brake       = 1'b1;
        motor_fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign pwm_out    = motor_enable & (pwm_cnt_q < duty_q);
  assign fault_code = code_q;

`ifdef DRUM_DIR_ALT_EN
  localparam logic [15:0] DIR_LAST = 16'(DIR_PERIOD - 1);

  logic        dir_q, dir_d;
  logic        rev_d;
  logic [15:0] dir_tick_q, dir_tick_d;

  // Tumble direction flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q      <= 1'b0;
      rev_q      <= 1'b0;
      dir_tick_q <= 16'd0;
    end else begin
      dir_q      <= dir_d;
      rev_q      <= rev_d;
      dir_tick_q <= dir_tick_d;
    end
  end

  // Count ramp ticks in RUN at tumble speeds; start a reversal, flip direction once braked.
  always_comb begin
    dir_d        = dir_q;
    rev_d        = rev_q;
    dir_tick_d   = dir_tick_q;
    tumble_start = 1'b0;
    if ((state_q == S_IDLE) || (state_q == S_FAULT)) begin
      rev_d      = 1'b0;
      dir_tick_d = 16'd0;
    end else if ((state_q == S_RUN) && !rev_q && (drum_motor != 4'd0) &&
                 (drum_motor <= TUMBLE_MAX_CMD)) begin
      if (tick) begin
        if (dir_tick_q == DIR_LAST) begin
          tumble_start = 1'b1;
          rev_d        = 1'b1;
          dir_tick_d   = 16'd0;
        end else begin
          dir_tick_d = dir_tick_q + 16'd1;
        end
      end
    end else if ((state_q == S_BRAKE) && rev_q && (brake_cnt_q == BRAKE_LAST)) begin
      rev_d = 1'b0;
      dir_d = ~dir_q;
    end else if (drum_motor > TUMBLE_MAX_CMD) begin
      dir_tick_d = 16'd0;
    end
  end

  assign motor_dir = dir_q;
`else
  logic unused_tumble;
  assign unused_tumble = ^{TUMBLE_MAX_CMD, 32'(DIR_PERIOD)};
  assign rev_q         = 1'b0;
  assign tumble_start  = 1'b0;
  assign motor_dir     = 1'b0;
`endif

endmodule
